// File: rtl/csr_arb_pkg.sv
// csr_arb_pkg
//   Shared definitions for the CSR request arbiter and its bench:
//   - arb_state_t : arbiter FSM states (IDLE / ISSUE / RESP)
//   - CSR_*       : memory-controller CSR address map
package csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic [7:0] CSR_CTRL   = 8'h00;
  localparam logic [7:0] CSR_STATUS = 8'h04;  // read-only
  localparam logic [7:0] CSR_CFG    = 8'h08;
  localparam logic [7:0] CSR_ERROR  = 8'h0C;
  localparam logic [7:0] CSR_ID     = 8'h10;  // read-only

endpackage

// File: rtl/csr_req_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin picker. The search starts one past the
//   previous winner and wraps modulo NUM_REQ.
//   Ports:
//     req      in  NUM_REQ : request vector
//     last_gnt in  IDX_W   : index of the previous winner
//     gnt      out NUM_REQ : one-hot grant (zero when no request)
//     idx      out IDX_W   : index of the granted requester
//     any      out 1       : at least one request present
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int           cand;
    logic [IDX_W-1:0] c;
    cand = 0;
    c    = '0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    // k = 1..NUM_REQ visits every requester once, the previous winner last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_gnt) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      c = cand[IDX_W-1:0];
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = c;
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_req_arbiter.sv
// csr_req_arbiter
//   Shares the memory controller's single CSR port between NUM_REQ
//   requesters. Round-robin, single outstanding transaction:
//   accept (IDLE) -> one-cycle strobe (ISSUE) -> response (RESP).
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     req_valid    : per-requester request, held until accepted
//     req_write    : per-requester 1 = write, 0 = read
//     req_addr     : packed addresses, slice [i*ADDR_W +: ADDR_W]
//     req_wdata    : packed write data, slice [i*DATA_W +: DATA_W]
//     req_ready    : one-hot acceptance pulse (IDLE only)
//     rsp_valid    : one-hot completion pulse (RESP only)
//     rsp_rdata    : read result, 0 after a write, held until next ISSUE
//     csr_wr_en/csr_rd_en/csr_addr/csr_wr_data : to controller (ISSUE only)
//     csr_rd_data  : from controller, combinational on csr_rd_en/csr_addr
//     busy         : state is not IDLE
module csr_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      csr_wr_en,
  output logic                      csr_rd_en,
  output logic [ADDR_W-1:0]         csr_addr,
  output logic [DATA_W-1:0]         csr_wr_data,
  input  logic [DATA_W-1:0]         csr_rd_data,
  output logic                      busy
);
  import csr_arb_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   last_gnt_reg;
  logic [IDX_W-1:0]   win_reg;
  logic               wr_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  rdata_reg;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;

  // Unpack the per-requester address/data buses for indexed selection.
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req_valid),
    .last_gnt (last_gnt_reg),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    csr_wr_en   = 1'b0;
    csr_rd_en   = 1'b0;
    csr_addr    = '0;
    csr_wr_data = '0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        // rst_n gating keeps req_ready quiet while reset is held, since
        // the state register already sits in IDLE during reset.
        if (pick_any && rst_n) begin
          accept     = 1'b1;
          req_ready  = pick_gnt;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        csr_wr_en   = wr_reg;
        csr_rd_en   = !wr_reg;
        csr_addr    = addr_reg;
        csr_wr_data = wdata_reg;
        state_next  = RESP;
      end
      RESP: begin
        rsp_valid[win_reg] = 1'b1;
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_reg <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
      win_reg      <= '0;
      wr_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      if (accept) begin
        win_reg   <= pick_idx;
        wr_reg    <= req_write[pick_idx];
        addr_reg  <= addr_arr[pick_idx];
        wdata_reg <= wdata_arr[pick_idx];
      end
      if (state_reg == ISSUE) rdata_reg <= wr_reg ? '0 : csr_rd_data;
      if (state_reg == RESP)  last_gnt_reg <= win_reg;
    end
  end

  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_csr_req_arbiter.sv
// tb_csr_req_arbiter
//   Bench for csr_req_arbiter with a small CSR controller model and a
//   scoreboard: accepted requests queue an expected strobe, observed
//   strobes queue an expected response.
module tb_csr_req_arbiter;
  import csr_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [31:0] STATUS_VAL = 32'h0000_00A5;
  localparam logic [31:0] ID_VAL     = 32'h1234_ABCD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata, csr_wr_data, csr_rd_data;
  logic            csr_wr_en, csr_rd_en, busy;
  logic [AW-1:0]   csr_addr;

  always #5 clk = ~clk;

  csr_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .csr_wr_en   (csr_wr_en),
    .csr_rd_en   (csr_rd_en),
    .csr_addr    (csr_addr),
    .csr_wr_data (csr_wr_data),
    .csr_rd_data (csr_rd_data),
    .busy        (busy)
  );

  // Memory-controller CSR model: STATUS and ID are read-only.
  logic [31:0] ctl_ctrl = '0, ctl_cfg = '0, ctl_err = '0;

  always @(posedge clk) begin
    if (csr_wr_en) begin
      case (csr_addr)
        CSR_CTRL:  ctl_ctrl <= csr_wr_data;
        CSR_CFG:   ctl_cfg  <= csr_wr_data;
        CSR_ERROR: ctl_err  <= csr_wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rd_data = '0;
    if (csr_rd_en) begin
      case (csr_addr)
        CSR_CTRL:   csr_rd_data = ctl_ctrl;
        CSR_STATUS: csr_rd_data = STATUS_VAL;
        CSR_CFG:    csr_rd_data = ctl_cfg;
        CSR_ERROR:  csr_rd_data = ctl_err;
        CSR_ID:     csr_rd_data = ID_VAL;
        default:    csr_rd_data = '0;
      endcase
    end
  end

  typedef struct {
    int          r;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    int          r;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
    logic [31:0] rdata;
  } txn_t;

  op_t  pend[$];
  txn_t strb_q[$];
  txn_t rsp_q[$];
  int   grant_log[$];
  int   rsp_cyc_log[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tb_last = N - 1;
  logic [31:0] ref_ctrl = '0, ref_cfg = '0, ref_err = '0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [7:0] a);
    case (a)
      CSR_CTRL:   return ref_ctrl;
      CSR_STATUS: return STATUS_VAL;
      CSR_CFG:    return ref_cfg;
      CSR_ERROR:  return ref_err;
      CSR_ID:     return ID_VAL;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (tb_last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Present the oldest pending op of every requester.
  task automatic drive();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].r == i) begin
          req_valid[i]           = 1'b1;
          req_write[i]           = pend[k].wr;
          req_addr[i*AW +: AW]   = pend[k].addr;
          req_wdata[i*DW +: DW]  = pend[k].data;
          break;
        end
      end
    end
  endtask

  // Called at the falling edge, away from the active edge.
  task automatic monitor();
    txn_t t;
    check("strobe_excl", csr_wr_en && csr_rd_en, 0);
    check("ready_when_busy", busy && (req_ready != 0), 0);
    if (req_ready != 0) begin
      int w;
      w = model_pick(req_valid);
      check("grant", req_ready, (w < 0) ? 0 : (1 << w));
      if (w >= 0) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].r == w) begin
            t = '{r: w, wr: pend[k].wr, addr: pend[k].addr, data: pend[k].data,
                  cyc: cyc, rdata: 32'h0};
            strb_q.push_back(t);
            pend.delete(k);
            break;
          end
        end
        grant_log.push_back(w);
        $display("accept   req=%0d wr=%0d addr=%02h data=%08h cyc=%0d", t.r, t.wr, t.addr, t.data, cyc);
        tb_last = w;
      end
    end
    if (csr_wr_en || csr_rd_en) begin
      if (strb_q.size() == 0) begin
        check("strobe_unexpected", 1, 0);
      end else begin
        t = strb_q.pop_front();
        check("csr_wr_en", csr_wr_en, t.wr);
        check("csr_rd_en", csr_rd_en, !t.wr);
        check("csr_addr", csr_addr, t.addr);
        if (t.wr) check("csr_wr_data", csr_wr_data, t.data);
        check("strobe_latency", cyc - t.cyc, 1);
        t.rdata = t.wr ? 32'h0 : ref_read(t.addr);
        t.cyc   = cyc;
        rsp_q.push_back(t);
      end
    end else begin
      check("csr_bus_quiet", {csr_addr, csr_wr_data}, 0);
    end
    if (rsp_valid != 0) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        t = rsp_q.pop_front();
        check("rsp_valid", rsp_valid, 1 << t.r);
        check("rsp_rdata", rsp_rdata, t.rdata);
        check("rsp_latency", cyc - t.cyc, 1);
        $display("response req=%0d wr=%0d addr=%02h rdata=%08h cyc=%0d", t.r, t.wr, t.addr, rsp_rdata, cyc);
        last_rdata = rsp_rdata;
        rsp_cyc_log.push_back(cyc);
        if (t.wr) begin
          case (t.addr)
            CSR_CTRL:  ref_ctrl = t.data;
            CSR_CFG:   ref_cfg  = t.data;
            CSR_ERROR: ref_err  = t.data;
            default: ;
          endcase
        end
      end
    end
  endtask

  // Entered and left at posedge+1. With abort set, drops rst_n just
  // after the first strobe is seen and returns with reset held.
  task automatic run(input int max_cycles, input bit abort, output bit aborted);
    bit saw_strobe;
    aborted = 1'b0;
    drive();
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      saw_strobe = csr_wr_en || csr_rd_en;
      monitor();
      if (abort && saw_strobe) begin
        #2 rst_n = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (pend.size() == 0 && strb_q.size() == 0 && rsp_q.size() == 0 && !busy) begin
        @(posedge clk);
        #1 drive();
        return;
      end
      @(posedge clk);
      #1 drive();
    end
    check("run_timeout", 1, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_handshake"}, {req_ready, rsp_valid}, 0);
    check({tag, "_strobe"}, {csr_wr_en, csr_rd_en, csr_addr}, 0);
    check({tag, "_wr_data"}, csr_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    req_valid = '0;
    strb_q.delete();
    rsp_q.delete();
    tb_last = N - 1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet({tag, "_in_reset"});
    check({tag, "_rdata"}, rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ab;
    int others;
    int exp3[5];
    int exp4[6];
    exp3 = '{0, 1, 2, 3, 0};
    exp4 = '{0, 2, 0, 2, 0, 2};

    #2;
    apply_reset("t0");
    check_quiet("t0_after_reset");

    // Requester 1 reads ID.
    grant_log.delete();
    pend.push_back('{r: 1, wr: 1'b0, addr: CSR_ID, data: 32'h0});
    run(50, 1'b0, ab);
    check("t1_grant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("t1_grant", grant_log[0], 1);
    check("t1_rdata", last_rdata, 32'h1234ABCD);

    // Requester 2 writes CFG then reads it back.
    grant_log.delete();
    pend.push_back('{r: 2, wr: 1'b1, addr: CSR_CFG, data: 32'h0000_0310});
    pend.push_back('{r: 2, wr: 1'b0, addr: CSR_CFG, data: 32'h0});
    run(50, 1'b0, ab);
    check("t2_grant_count", grant_log.size(), 2);
    check("t2_rdata", last_rdata, 32'h0000_0310);
    check("t2_burst_length", ctl_cfg[7:0], 8'h10);
    check("t2_latency", ctl_cfg[11:8], 4'd3);

    // All four requesters valid from reset.
    apply_reset("t3");
    grant_log.delete();
    rsp_cyc_log.delete();
    pend.push_back('{r: 0, wr: 1'b0, addr: CSR_ID,     data: 32'h0});
    pend.push_back('{r: 1, wr: 1'b0, addr: CSR_CTRL,   data: 32'h0});
    pend.push_back('{r: 2, wr: 1'b0, addr: CSR_CFG,    data: 32'h0});
    pend.push_back('{r: 3, wr: 1'b1, addr: CSR_ERROR,  data: 32'h0000_00E7});
    pend.push_back('{r: 0, wr: 1'b0, addr: CSR_STATUS, data: 32'h0});
    run(100, 1'b0, ab);
    check("t3_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("t3_order", grant_log[i], exp3[i]);
    for (int i = 1; i < rsp_cyc_log.size(); i++)
      check("t3_rsp_spacing", rsp_cyc_log[i] - rsp_cyc_log[i-1], 3);

    // Requesters 0 and 2 held valid continuously.
    apply_reset("t4");
    grant_log.delete();
    rsp_cyc_log.delete();
    for (int i = 0; i < 3; i++) begin
      pend.push_back('{r: 0, wr: 1'b1, addr: CSR_ERROR, data: 32'h100 + i});
      pend.push_back('{r: 2, wr: 1'b0, addr: CSR_ERROR, data: 32'h0});
    end
    run(100, 1'b0, ab);
    check("t4_grant_count", grant_log.size(), 6);
    others = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      if (i < 6) check("t4_order", grant_log[i], exp4[i]);
      if (grant_log[i] == 1 || grant_log[i] == 3) others++;
    end
    check("t4_others_granted", others, 0);
    for (int i = 1; i < rsp_cyc_log.size(); i++)
      check("t4_rsp_spacing", rsp_cyc_log[i] - rsp_cyc_log[i-1], 3);

    // Reset during ISSUE of a write by requester 3.
    apply_reset("t5");
    grant_log.delete();
    pend.push_back('{r: 3, wr: 1'b1, addr: CSR_CTRL, data: 32'h1});
    run(50, 1'b1, ab);
    check("t5_aborted", ab, 1);
    #1;
    check_quiet("t5_abort");
    check("t5_abort_rdata", rsp_rdata, 0);
    strb_q.delete();
    rsp_q.delete();
    tb_last = N - 1;
    repeat (2) begin
      @(negedge clk);
      check("t5_no_rsp_in_reset", rsp_valid, 0);
    end
    check("t5_ctrl_unwritten", ctl_ctrl, 0);
    grant_log.delete();
    pend.push_back('{r: 3, wr: 1'b0, addr: CSR_CTRL, data: 32'h0});
    pend.push_back('{r: 0, wr: 1'b0, addr: CSR_CTRL, data: 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(50, 1'b0, ab);
    check("t5_grant_count", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      check("t5_first_grant", grant_log[0], 0);
      check("t5_second_grant", grant_log[1], 3);
    end
    check("t5_ctrl_read", last_rdata, 0);

    // Write to read-only STATUS still completes; value unchanged.
    rsp_cyc_log.delete();
    pend.push_back('{r: 1, wr: 1'b1, addr: CSR_STATUS, data: 32'hFFFF_FFFF});
    pend.push_back('{r: 1, wr: 1'b0, addr: CSR_STATUS, data: 32'h0});
    run(50, 1'b0, ab);
    check("t6_rsp_count", rsp_cyc_log.size(), 2);
    check("t6_status", last_rdata, 32'h0000_00A5);

    check("sb_drain", strb_q.size() + rsp_q.size() + pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the bench itself wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csr_req_arbiter.md
# csr_req_arbiter

Shares the single CSR port of the memory controller between `NUM_REQ` independent requesters, such as the host bridge, the self-test engine and the error scrubber. The block uses round-robin arbitration and a three-phase accept/issue/respond sequence. It is a single-outstanding master: it accepts one request, drives exactly one one-cycle CSR strobe, and returns the result to the winning requester. It sits between the requester agents and the memory controller's `csr_*` inputs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 8: CSR address width.
- `DATA_W`, 32: CSR data width.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ: per-requester request; must be held until accepted.
- `req_write`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W: packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W: packed write data.
- `req_ready`  out  NUM_REQ: one-hot acceptance pulse.
- `rsp_valid`  out  NUM_REQ: one-hot completion pulse, no backpressure.
- `rsp_rdata`  out  DATA_W: read result (shared); 0 for writes.
- `csr_wr_en`  out  1: to controller.
- `csr_rd_en`  out  1: to controller.
- `csr_addr`  out  ADDR_W: to controller.
- `csr_wr_data`  out  DATA_W: to controller.
- `csr_rd_data`  in  DATA_W: from controller; combinational with `csr_rd_en`/`csr_addr`.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If any `req_valid` bit is set, pick the winner by round-robin. The search starts at `last_gnt+1` and wraps modulo NUM_REQ.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - Latch winner index, write flag, address and write data, then go to ISSUE.
- ISSUE:
  - Drive the latched `csr_addr`/`csr_wr_data`. Assert exactly one of `csr_wr_en` or `csr_rd_en` for this single cycle.
  - On a read, register `csr_rd_data` into `rsp_rdata` at the clock edge ending the cycle. On a write, load `rsp_rdata` with 0.
  - Go to RESP.
- RESP:
  - Assert `rsp_valid[winner]` for one cycle while `rsp_rdata` is valid.
  - Set `last_gnt` to the winner and go to IDLE.
- `rsp_rdata` holds its value until the next ISSUE.
- `csr_addr`/`csr_wr_data` are zero outside ISSUE.
- `csr_wr_en` and `csr_rd_en` are never high together and are never high outside ISSUE.
- `req_ready` and `rsp_valid` are zero outside IDLE and RESP respectively.
- `req_valid` changes during ISSUE/RESP are ignored. Only IDLE samples requests.
- Deasserting `req_valid` before acceptance is a protocol violation. The arbiter does not guard against it.
- Writes to read-only addresses are forwarded unchanged. The controller ignores them and the arbiter still returns `rsp_valid`.

## Timing
- Reset values: state IDLE, `last_gnt` = NUM_REQ-1 (requester 0 wins first), every output 0, `rsp_rdata` = 0.
- Accept in cycle T, CSR strobe in T+1, `rsp_valid` in T+2. The earliest next accept is T+3, giving a throughput of 1 transaction per 3 cycles.
- Simultaneous requests are resolved by the round-robin pointer, so no requester waits more than NUM_REQ-1 transactions.
- A single persistent requester is served back-to-back every 3 cycles.
- Reset asserted mid-ISSUE or mid-RESP aborts the transaction: no `rsp_valid` is produced, and a strobe is cut immediately (asynchronously). The requester must reissue.

## Structure
- `csr_arb_pkg`: state enum (IDLE/ISSUE/RESP) and CSR address constants (CTRL 0x00, STATUS 0x04, CFG 0x08, ERROR 0x0C, ID 0x10). The package is shared with the bench.
- Sub-module `rr_picker`: combinational; inputs are the request vector and `last_gnt`; outputs are the one-hot grant and the index.

## Test plan
- Reset, then requester 1 reads 0x10 → `req_ready[1]` in T, `csr_rd_en`=1 with `csr_addr`=0x10 in T+1, `rsp_valid[1]` in T+2 with `rsp_rdata`=0x1234ABCD.
- Requester 2 writes 0x0000_0310 to 0x08, then reads 0x08 → write response has `rsp_rdata`=0; read returns 0x0000_0310; controller shows `mem_burst_length`=0x10 and `mem_latency`=3.
- All four requesters valid from reset → grant order 0,1,2,3,0. Each `rsp_valid` arrives 3 cycles apart, and `csr_*` strobes are never overlapped.
- Requesters 0 and 2 held valid continuously → grants alternate 0,2,0,2; requesters 1 and 3 never see `req_ready`.
- Requester 3 writes 0x1 to 0x00 and `rst_n` drops during ISSUE → all outputs 0 immediately; no `rsp_valid`; after release, the first grant goes to requester 0 if it is valid.
- Write to 0x04 (STATUS, read-only) → `rsp_valid` is returned; a subsequent read of 0x04 shows an unchanged value.
